// File: rtl/axi_master_bridge.sv
// axi_master_bridge
//   Converts the cache bridge's request/beat handshake into AXI4 master
//   channels. The read path (AR/R) and the write path (AW/W/B) are separate
//   state machines, so one read burst and one write burst can be in flight
//   at the same time.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   cpu_ce_i              enable; low blocks new bursts from starting
//   cpu_ren_i/raddr/rlen  read request level, start address, beats-1
//   cpu_rready_i          upstream can take a read beat
//   cpu_rdata_o/rvalid_o  read beat data and "beat transferred" strobe
//   cpu_wen_i/waddr/wlen  write request level, start address, beats-1
//   cpu_wdata_i/wsel_i    current write beat data and byte strobes
//   cpu_wresp_o           pulse per accepted non-last beat, plus one on B
//   m_ar*/m_r*            AXI read address / read data channels
//   m_aw*/m_w*/m_b*       AXI write address / write data / response channels
//   dbg_rstate/dbg_wstate current read / write FSM state
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Every valid here comes from a register and never looks at
// the matching ready; once raised it stays high until its transfer.
module axi_master_bridge #(
  parameter logic [3:0] RD_ID = 4'h0,
  parameter logic [3:0] WR_ID = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_ren_i,
  input  logic [31:0] cpu_raddr_i,
  input  logic [7:0]  cpu_rlen_i,
  input  logic        cpu_rready_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_rvalid_o,
  input  logic        cpu_wen_i,
  input  logic [31:0] cpu_waddr_i,
  input  logic [7:0]  cpu_wlen_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_wsel_i,
  output logic        cpu_wresp_o,
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [3:0]  m_awid,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [3:0]  m_bid,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [1:0]  dbg_rstate,
  output logic [2:0]  dbg_wstate
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_t;
  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_RESP, W_DONE} w_state_t;

  r_state_t   r_state;
  w_state_t   w_state;
  logic [7:0] wcnt;

  // Response codes and IDs coming back from the interconnect are not used.
  logic unused_inputs;
  assign unused_inputs = ^{m_rid, m_rresp, m_bid, m_bresp};

  assign m_arid    = RD_ID;
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign m_awid    = WR_ID;
  assign m_awsize  = 3'b010;
  assign m_awburst = 2'b01;

  assign dbg_rstate = r_state;
  assign dbg_wstate = w_state;

  // ---------------- read path ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= R_IDLE;
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arvalid <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: if (cpu_ce_i && cpu_ren_i) begin
          r_state   <= R_ADDR;
          m_araddr  <= cpu_raddr_i;
          m_arlen   <= cpu_rlen_i;
          m_arvalid <= 1'b1;
        end
        R_ADDR: if (m_arready) begin
          m_arvalid <= 1'b0;
          r_state   <= R_DATA;
        end
        R_DATA: if (m_rvalid && cpu_rready_i && m_rlast) r_state <= R_DONE;
        // One dead cycle so the upstream can drop ren before IDLE looks again.
        R_DONE: r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Ready is a straight pass of the upstream ready while receiving data, so
  // beats reach the upstream in the same cycle they are accepted.
  assign m_rready     = (r_state == R_DATA) && cpu_rready_i;
  assign cpu_rvalid_o = m_rvalid && m_rready;
  assign cpu_rdata_o  = m_rdata;

  // ---------------- write path ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state   <= W_IDLE;
      m_awaddr  <= '0;
      m_awlen   <= '0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      wcnt      <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (cpu_ce_i && cpu_wen_i) begin
          w_state   <= W_ADDR;
          m_awaddr  <= cpu_waddr_i;
          m_awlen   <= cpu_wlen_i;
          m_awvalid <= 1'b1;
          wcnt      <= '0;
        end
        W_ADDR: if (m_awready) begin
          m_awvalid <= 1'b0;
          m_wvalid  <= 1'b1;
          w_state   <= W_DATA;
        end
        W_DATA: if (m_wready) begin
          wcnt <= wcnt + 8'd1;
          if (m_wlast) begin
            m_wvalid <= 1'b0;
            m_bready <= 1'b1;
            w_state  <= W_RESP;
          end
        end
        W_RESP: if (m_bvalid) begin
          m_bready <= 1'b0;
          w_state  <= W_DONE;
        end
        W_DONE: w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign m_wdata = cpu_wdata_i;
  assign m_wstrb = cpu_wsel_i;
  assign m_wlast = m_wvalid && (wcnt == m_awlen);

  // The upstream advances its data on each pulse; the last beat's pulse is
  // held back until B so the final pulse means the write has completed.
  assign cpu_wresp_o = (m_wvalid && m_wready && !m_wlast) || (m_bready && m_bvalid);

endmodule

// File: tb/tb_axi_master_bridge.sv
module tb_axi_master_bridge;

  localparam logic [3:0] RD_ID = 4'h0;
  localparam logic [3:0] WR_ID = 4'h1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i, cpu_ren_i, cpu_rready_i, cpu_wen_i;
  logic [31:0] cpu_raddr_i, cpu_waddr_i, cpu_wdata_i;
  logic [7:0]  cpu_rlen_i, cpu_wlen_i;
  logic [3:0]  cpu_wsel_i;
  logic [31:0] cpu_rdata_o;
  logic        cpu_rvalid_o, cpu_wresp_o;
  logic [3:0]  m_arid, m_awid, m_rid, m_bid, m_wstrb;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic        m_bvalid, m_bready;
  logic [1:0]  dbg_rstate;
  logic [2:0]  dbg_wstate;

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  axi_master_bridge #(.RD_ID(RD_ID), .WR_ID(WR_ID)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_ren_i(cpu_ren_i), .cpu_raddr_i(cpu_raddr_i),
    .cpu_rlen_i(cpu_rlen_i), .cpu_rready_i(cpu_rready_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o),
    .cpu_wen_i(cpu_wen_i), .cpu_waddr_i(cpu_waddr_i), .cpu_wlen_i(cpu_wlen_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_wsel_i(cpu_wsel_i), .cpu_wresp_o(cpu_wresp_o),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .dbg_rstate(dbg_rstate), .dbg_wstate(dbg_wstate)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Read burst: request, AR (arready after ar_delay cycles), len+1 beats with
  // optional rvalid gaps and a 2-cycle upstream stall at beat stall_at, then
  // the one-cycle done gap with ren still high.
  task automatic do_read(input logic [31:0] addr, input int len, input int ar_delay,
                         input bit gaps, input int stall_at, input bit fixed);
    logic [31:0] rd [256];
    logic [31:0] exp;
    int beat, cyc, ar_wait, stall;
    bit ar_done, hold, hs;
    beat = 0; cyc = 0; ar_wait = 0; stall = 0; ar_done = 0; hold = 0;
    for (int i = 0; i <= len; i++) begin
      rd[i] = fixed ? 32'(32'hA0 + i) : $urandom();
      exp_q.push_back(rd[i]);
    end
    @(posedge clk); #1;
    cpu_ce_i = 1'b1; cpu_ren_i = 1'b1; cpu_raddr_i = addr; cpu_rlen_i = 8'(len);
    #1;
    checks++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL ar_early got=%b exp=0", m_arvalid); end
    while (beat <= len && cyc < 300) begin
      @(posedge clk); #1; cyc++;
      if (!ar_done) begin
        m_arready = (ar_wait >= ar_delay); m_rvalid = 1'b0; m_rlast = 1'b0; cpu_rready_i = 1'b1;
      end else begin
        m_arready = 1'b0;
        if (!hold) m_rvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        m_rdata = m_rvalid ? rd[beat] : $urandom();
        m_rlast = m_rvalid && (beat == len);
        if (beat == stall_at && stall < 2) begin cpu_rready_i = 1'b0; stall++; end
        else cpu_rready_i = 1'b1;
      end
      #1;
      if (!ar_done) begin
        checks++; if (m_arvalid !== 1'b1) begin fails++; $display("FAIL ar_valid cyc=%0d got=%b exp=1", cyc, m_arvalid); end
        checks++; if ({m_araddr, m_arlen} !== {addr, 8'(len)}) begin fails++; $display("FAIL ar_addr_len got=%h/%0d exp=%h/%0d", m_araddr, m_arlen, addr, len); end
        checks++; if ({m_arid, m_arsize, m_arburst} !== {RD_ID, 3'b010, 2'b01}) begin fails++; $display("FAIL ar_const got=%h exp=%h", {m_arid, m_arsize, m_arburst}, {RD_ID, 3'b010, 2'b01}); end
        if (m_arvalid && m_arready) ar_done = 1;
        ar_wait++;
      end else begin
        hs = m_rvalid && cpu_rready_i;
        checks++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL ar_repeat got=%b exp=0", m_arvalid); end
        checks++; if (m_rready !== cpu_rready_i) begin fails++; $display("FAIL r_ready got=%b exp=%b", m_rready, cpu_rready_i); end
        checks++; if (cpu_rvalid_o !== hs) begin fails++; $display("FAIL cpu_rvalid beat=%0d got=%b exp=%b", beat, cpu_rvalid_o, hs); end
        if (hs) begin
          exp = exp_q.pop_front();
          checks++; if (cpu_rdata_o !== exp) begin fails++; $display("FAIL cpu_rdata beat=%0d got=%h exp=%h", beat, cpu_rdata_o, exp); end
          beat++;
        end
        hold = m_rvalid && !hs;
      end
    end
    if (cyc >= 300) begin
      checks++; fails++; $display("FAIL read_timeout got=%0d beats exp=%0d", beat, len + 1);
      exp_q.delete();
    end
    @(posedge clk); #1;
    m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b1;
    #1;
    checks++; if ({m_arvalid, m_rready, cpu_rvalid_o} !== 3'b000) begin fails++; $display("FAIL r_done_outs got=%b exp=000", {m_arvalid, m_rready, cpu_rvalid_o}); end
    checks++; if (dbg_rstate !== 2'd3) begin fails++; $display("FAIL r_done_state got=%0d exp=3", dbg_rstate); end
    @(posedge clk); #1;
    cpu_ren_i = 1'b0; m_arready = 1'b0;
    #1;
    checks++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL ar_after_done got=%b exp=0", m_arvalid); end
  endtask

  // Write burst: request, AW, len+1 W beats (one wready stall at stall_beat),
  // B after b_delay cycles of waiting. The upstream advances on each pulse.
  task automatic do_write(input logic [31:0] addr, input int len, input int aw_delay,
                          input int stall_beat, input int b_delay, input bit fixed);
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    int beat, cyc, phase, aw_wait, bw, nresp;
    bit stalled, exp_resp;
    beat = 0; cyc = 0; phase = 0; aw_wait = 0; bw = 0; nresp = 0; stalled = 0;
    for (int i = 0; i <= len; i++) begin
      wd[i] = fixed ? 32'(32'h11 * (i + 1)) : $urandom();
      ws[i] = 4'($urandom_range(0, 15));
    end
    @(posedge clk); #1;
    cpu_ce_i = 1'b1; cpu_wen_i = 1'b1; cpu_waddr_i = addr; cpu_wlen_i = 8'(len);
    cpu_wdata_i = wd[0]; cpu_wsel_i = ws[0];
    #1;
    checks++; if (m_awvalid !== 1'b0) begin fails++; $display("FAIL aw_early got=%b exp=0", m_awvalid); end
    while (phase != 3 && cyc < 300) begin
      @(posedge clk); #1; cyc++;
      m_awready = (phase == 0) && (aw_wait >= aw_delay);
      m_wready = 1'b0; m_bvalid = 1'b0;
      if (phase == 1) begin
        cpu_wdata_i = wd[beat]; cpu_wsel_i = ws[beat];
        m_wready = !(beat == stall_beat && !stalled);
        if (beat == stall_beat) stalled = 1;
      end
      if (phase == 2) begin m_bvalid = (bw >= b_delay); bw++; end
      #1;
      if (phase == 0) begin
        checks++; if (m_awvalid !== 1'b1) begin fails++; $display("FAIL aw_valid cyc=%0d got=%b exp=1", cyc, m_awvalid); end
        checks++; if ({m_awaddr, m_awlen} !== {addr, 8'(len)}) begin fails++; $display("FAIL aw_addr_len got=%h/%0d exp=%h/%0d", m_awaddr, m_awlen, addr, len); end
        checks++; if ({m_awid, m_awsize, m_awburst} !== {WR_ID, 3'b010, 2'b01}) begin fails++; $display("FAIL aw_const got=%h exp=%h", {m_awid, m_awsize, m_awburst}, {WR_ID, 3'b010, 2'b01}); end
        checks++; if ({m_wvalid, m_bready, cpu_wresp_o} !== 3'b000) begin fails++; $display("FAIL aw_phase_outs got=%b exp=000", {m_wvalid, m_bready, cpu_wresp_o}); end
        if (m_awvalid && m_awready) phase = 1;
        aw_wait++;
      end else if (phase == 1) begin
        exp_resp = m_wready && (beat != len);
        checks++; if ({m_awvalid, m_wvalid, m_bready} !== 3'b010) begin fails++; $display("FAIL w_phase_outs got=%b exp=010", {m_awvalid, m_wvalid, m_bready}); end
        checks++; if ({m_wdata, m_wstrb} !== {wd[beat], ws[beat]}) begin fails++; $display("FAIL w_data beat=%0d got=%h/%h exp=%h/%h", beat, m_wdata, m_wstrb, wd[beat], ws[beat]); end
        checks++; if (m_wlast !== ((beat == len) ? 1'b1 : 1'b0)) begin fails++; $display("FAIL w_last beat=%0d got=%b", beat, m_wlast); end
        checks++; if (cpu_wresp_o !== exp_resp) begin fails++; $display("FAIL w_resp_beat beat=%0d got=%b exp=%b", beat, cpu_wresp_o, exp_resp); end
        if (cpu_wresp_o) nresp++;
        if (m_wready) begin
          if (beat == len) phase = 2; else beat++;
        end
      end else begin
        checks++; if ({m_wvalid, m_bready} !== 2'b01) begin fails++; $display("FAIL b_phase_outs got=%b exp=01", {m_wvalid, m_bready}); end
        checks++; if (cpu_wresp_o !== m_bvalid) begin fails++; $display("FAIL w_resp_b got=%b exp=%b", cpu_wresp_o, m_bvalid); end
        if (cpu_wresp_o) nresp++;
        if (m_bvalid) phase = 3;
      end
    end
    if (cyc >= 300) begin checks++; fails++; $display("FAIL write_timeout phase=%0d exp=3", phase); end
    checks++; if (nresp != len + 1) begin fails++; $display("FAIL w_resp_count got=%0d exp=%0d", nresp, len + 1); end
    @(posedge clk); #1;
    m_bvalid = 1'b0; m_wready = 1'b0; m_awready = 1'b1;
    #1;
    checks++; if ({m_awvalid, m_wvalid, m_bready, cpu_wresp_o} !== 4'b0000) begin fails++; $display("FAIL w_done_outs got=%b exp=0000", {m_awvalid, m_wvalid, m_bready, cpu_wresp_o}); end
    checks++; if (dbg_wstate !== 3'd4) begin fails++; $display("FAIL w_done_state got=%0d exp=4", dbg_wstate); end
    @(posedge clk); #1;
    cpu_wen_i = 1'b0; m_awready = 1'b0;
    #1;
    checks++; if (m_awvalid !== 1'b0) begin fails++; $display("FAIL aw_after_done got=%b exp=0", m_awvalid); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_ce_i = 1'b0; cpu_ren_i = 1'b0; cpu_wen_i = 1'b0; cpu_rready_i = 1'b1;
    cpu_raddr_i = '0; cpu_rlen_i = '0; cpu_waddr_i = '0; cpu_wlen_i = '0;
    cpu_wdata_i = '0; cpu_wsel_i = '0;
    m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b0; m_rdata = 32'hDEAD_BEEF;
    m_rid = '0; m_rresp = '0; m_awready = 1'b0; m_wready = 1'b1;
    m_bvalid = 1'b1; m_bid = '0; m_bresp = '0;
    #12;
    checks++; if ({m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready} !== 5'b0) begin fails++; $display("FAIL reset_valids got=%b exp=00000", {m_arvalid, m_awvalid, m_wvalid, m_bready, m_rready}); end
    checks++; if ({cpu_rvalid_o, cpu_wresp_o} !== 2'b00) begin fails++; $display("FAIL reset_cpu_outs got=%b exp=00", {cpu_rvalid_o, cpu_wresp_o}); end
    checks++; if ({m_araddr, m_arlen, m_awaddr, m_awlen} !== 80'h0) begin fails++; $display("FAIL reset_addr_len got=%h exp=0", {m_araddr, m_arlen, m_awaddr, m_awlen}); end
    checks++; if ({m_arid, m_arsize, m_arburst, m_awid, m_awsize, m_awburst} !== {RD_ID, 3'b010, 2'b01, WR_ID, 3'b010, 2'b01}) begin fails++; $display("FAIL reset_consts got=%h", {m_arid, m_arsize, m_arburst, m_awid, m_awsize, m_awburst}); end
    checks++; if ({dbg_rstate, dbg_wstate} !== 5'b0) begin fails++; $display("FAIL reset_state got=%b exp=0", {dbg_rstate, dbg_wstate}); end
    m_rvalid = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_rdata = '0;
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_ce_gate();
    @(posedge clk); #1;
    cpu_ce_i = 1'b0; cpu_ren_i = 1'b1; cpu_raddr_i = 32'h2000_0100; cpu_rlen_i = 8'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      checks++; if (m_arvalid !== 1'b0) begin fails++; $display("FAIL ce_block cyc=%0d got=%b exp=0", i, m_arvalid); end
    end
    do_read(32'h2000_0100, 1, 0, 0, -1, 0);
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    cpu_ce_i = 1'b1; cpu_ren_i = 1'b1; cpu_raddr_i = 32'h3000_0040; cpu_rlen_i = 8'd3;
    cpu_rready_i = 1'b1;
    @(posedge clk); #1; m_arready = 1'b1;
    @(posedge clk); #1; m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h1;
    @(posedge clk); #1; m_rdata = 32'h2;
    @(posedge clk); #1; m_rdata = 32'h3;
    #1;
    checks++; if (cpu_rvalid_o !== 1'b1) begin fails++; $display("FAIL rst_pre_beat got=%b exp=1", cpu_rvalid_o); end
    rst = 1'b0;
    #1;
    checks++; if ({m_rready, cpu_rvalid_o, m_arvalid} !== 3'b000) begin fails++; $display("FAIL rst_mid_outs got=%b exp=000", {m_rready, cpu_rvalid_o, m_arvalid}); end
    checks++; if (dbg_rstate !== 2'd0) begin fails++; $display("FAIL rst_mid_state got=%0d exp=0", dbg_rstate); end
    m_rvalid = 1'b0; cpu_ren_i = 1'b0;
    @(negedge clk); rst = 1'b1;
    do_read(32'h3000_0080, 2, 1, 0, -1, 0);
  endtask

  task automatic test_concurrent();
    fork
      do_read(32'h4000_0000, 5, 1, 1, 2, 0);
      do_write(32'h5000_0000, 4, 0, 1, 1, 0);
    join
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      fork
        do_read({$urandom_range(0, 32'hFFFF), 4'h0, 12'h0}, $urandom_range(0, 15),
                $urandom_range(0, 3), 1, $urandom_range(0, 15), 0);
        do_write({$urandom_range(0, 32'hFFFF), 4'h0, 12'h0}, $urandom_range(0, 15),
                 $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 4), 0);
      join
    end
  endtask

  initial begin
    test_reset();
    do_read(32'h1C00_0020, 3, 2, 1, -1, 1);
    do_read(32'h1C00_1000, 6, 0, 1, 3, 0);
    do_write(32'h1C00_2000, 3, 1, 2, 2, 1);
    test_concurrent();
    test_ce_gate();
    test_reset_mid_read();
    do_read(32'h6000_0000, 0, 0, 0, -1, 0);
    do_write(32'h6000_1000, 0, 0, -1, 0, 0);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
